// File: rtl/operand_loader.sv
// Serial-to-parallel operand loader: collects eight operands a..h from a valid/ready
// stream, presents them in parallel and carries the exact sum as a golden reference.
module operand_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+2:0] exact_sum,
  output logic [2:0]       count
);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [WIDTH+2:0] sum_q, sum_d;
  logic [WIDTH-1:0] slot_q [8];
  logic             load;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sum_d    = sum_q;
    load     = 1'b0;
    unique case (state_q)
      StFill: begin
        // clr wins over a simultaneous operand, which is dropped
        if (clr) begin
          count_d = 3'd0;
          sum_d   = '0;
        end else if (in_valid) begin
          load    = 1'b1;
          count_d = count_q + 3'd1;
          sum_d   = sum_q + {3'b000, in_data};
          if (count_q == 3'd7) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (out_ready) begin
          state_d = StFill;
          sum_d   = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      count_q <= 3'd0;
      sum_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      if (load) begin
        slot_q[count_q] <= in_data;
      end
    end
  end

  // in_ready is held low while reset is asserted
  assign in_ready  = (state_q == StFill) && !rst;
  assign out_valid = (state_q == StFull);
  assign exact_sum = sum_q;
  assign count     = count_q;

  assign a = slot_q[0];
  assign b = slot_q[1];
  assign c = slot_q[2];
  assign d = slot_q[3];
  assign e = slot_q[4];
  assign f = slot_q[5];
  assign g = slot_q[6];
  assign h = slot_q[7];

endmodule

// File: tb/tb_operand_loader.sv
// Randomized bench for operand_loader: a queue-based model of the current operand set
// is checked against the DUT on every falling edge, plus literal spot checks.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a, b, c, d, e, f, g, h;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] exact_sum;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;

  operand_loader #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_valid(out_valid), .out_ready(out_ready), .exact_sum(exact_sum), .count(count)
  );

  always #5 clk = ~clk;

  // Model: operands accepted into the current set, plus the last value written per slot.
  int   m_set[$];
  bit   m_full;
  int   m_slot[8];

  function automatic int m_sum();
    int s = 0;
    foreach (m_set[i]) s += m_set[i];
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_set.delete();
      m_full = 1'b0;
      for (int i = 0; i < 8; i++) m_slot[i] = 0;
    end else if (m_full) begin
      if (out_ready) begin
        m_full = 1'b0;
        m_set.delete();
      end
    end else if (clr) begin
      m_set.delete();
    end else if (in_valid) begin
      m_slot[m_set.size()] = int'(in_data);
      m_set.push_back(int'(in_data));
      if (m_set.size() == 8) m_full = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", int'(out_valid), int'(m_full));
      chk("in_ready", int'(in_ready), int'(!m_full));
      chk("count", int'(count), m_full ? 0 : m_set.size());
      chk("exact_sum", int'(exact_sum), m_sum());
      chk("a", int'(a), m_slot[0]);
      chk("b", int'(b), m_slot[1]);
      chk("c", int'(c), m_slot[2]);
      chk("d", int'(d), m_slot[3]);
      chk("e", int'(e), m_slot[4]);
      chk("f", int'(f), m_slot[5]);
      chk("g", int'(g), m_slot[6]);
      chk("h", int'(h), m_slot[7]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 8'(v);
    step();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_sum"}, int'(exact_sum), 0);
    chk({tag, "_a"}, int'(a), 0);
    chk({tag, "_h"}, int'(h), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    #12;
    check_reset_values("rst0");
    rst = 1'b0;
    #1;
    chk("rst0_in_ready", int'(in_ready), 1);
    step();

    // Back-to-back 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      chk("b2b_not_valid_yet", int'(out_valid), 0);
      step();
    end
    in_valid = 1'b0;
    chk("seq_out_valid", int'(out_valid), 1);
    chk("seq_in_ready", int'(in_ready), 0);
    chk("seq_a", int'(a), 1);
    chk("seq_h", int'(h), 8);
    chk("seq_sum", int'(exact_sum), 36);

    // Stall in FULL with 0xFF offered
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 10; i++) step();
    chk("stall_sum", int'(exact_sum), 36);
    chk("stall_d", int'(d), 4);
    handshake();
    chk("bubble_count", int'(count), 0);
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    chk("ff_sum", int'(exact_sum), 2040);
    chk("ff_e", int'(e), 255);
    chk("ff_valid", int'(out_valid), 1);
    handshake();

    // Partial fill aborted by clr with a simultaneous operand
    send(10); send(20); send(30);
    chk("partial_count", int'(count), 3);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_count", int'(count), 0);
    chk("clr_sum", int'(exact_sum), 0);
    for (int i = 1; i <= 8; i++) send(i);
    chk("clr_set_sum", int'(exact_sum), 36);
    chk("clr_set_a", int'(a), 1);
    handshake();

    // Gappy fill of fives
    begin
      int guard = 0;
      in_data = 8'd5;
      while (!out_valid && guard < 200) begin
        in_valid = 1'($urandom_range(0, 1));
        step();
        guard++;
      end
      in_valid = 1'b0;
      chk("fives_timeout", int'(guard < 200), 1);
      chk("fives_sum", int'(exact_sum), 40);
    end
    handshake();

    // Asynchronous reset at count 4 and again in FULL
    for (int i = 1; i <= 4; i++) send(i * 3);
    #1 rst = 1'b1;
    #1 check_reset_values("arst_fill");
    @(negedge clk); #1 rst = 1'b0;
    step();
    for (int i = 1; i <= 8; i++) send(i + 100);
    chk("pre_arst_full", int'(out_valid), 1);
    #1 rst = 1'b1;
    #1 check_reset_values("arst_full");
    @(negedge clk); #1 rst = 1'b0;
    step();
    for (int i = 1; i <= 8; i++) send(i);
    chk("post_arst_sum", int'(exact_sum), 36);
    chk("post_arst_g", int'(g), 7);
    handshake();

    // Random traffic, fully checked by the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      clr       = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
